// File: rtl/snn_noc_pkg.sv
// Shared NoC definitions for the spiking convolution array: packet layout,
// type codes, node addresses and a packet builder. Used by the adder nodes,
// PEs, memory wrapper and router.
package snn_noc_pkg;

  localparam int unsigned NOC_W     = 34;
  localparam int unsigned PAYLOAD_W = 24;

  // Field positions inside a packet.
  localparam int unsigned SRC_MSB     = 33;
  localparam int unsigned SRC_LSB     = 30;
  localparam int unsigned DST_MSB     = 29;
  localparam int unsigned DST_LSB     = 26;
  localparam int unsigned TYPE_MSB    = 25;
  localparam int unsigned TYPE_LSB    = 24;
  localparam int unsigned PAYLOAD_MSB = 23;

  // Packet type codes; input spikes and partial sums share code 00.
  localparam logic [1:0] TYPE_INPUT  = 2'b00;
  localparam logic [1:0] TYPE_PSUM   = 2'b00;
  localparam logic [1:0] TYPE_KERNEL = 2'b01;
  localparam logic [1:0] TYPE_MEM    = 2'b10;
  localparam logic [1:0] TYPE_SPIKE  = 2'b11;

  // Node addresses.
  localparam logic [3:0] ADDR_ADDER0  = 4'b0001;
  localparam logic [3:0] ADDR_ADDER1  = 4'b0101;
  localparam logic [3:0] ADDR_ADDER2  = 4'b1001;
  localparam logic [3:0] ADDR_WRAPPER = 4'b0100;
  localparam logic [3:0] ADDR_PE1     = 4'b0010;
  localparam logic [3:0] ADDR_PE2     = 4'b0110;
  localparam logic [3:0] ADDR_PE3     = 4'b1010;

  // A spike payload whose low nibble is all ones is read as DONE by the wrapper.
  localparam logic [3:0]  DONE_NIBBLE  = 4'hF;
  localparam logic [23:0] DONE_PAYLOAD = 24'hFFFFFF;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [1:0]  ptype;
    logic [23:0] payload;
  } noc_pkt_t;

  function automatic noc_pkt_t pkt_make(input logic [3:0]  src,
                                        input logic [3:0]  dst,
                                        input logic [1:0]  ptype,
                                        input logic [23:0] payload);
    noc_pkt_t p;
    p.src     = src;
    p.dst     = dst;
    p.ptype   = ptype;
    p.payload = payload;
    return p;
  endfunction

endpackage

// File: rtl/snn_psum_collector.sv
// Gathers the three partial sums and the old membrane potential of one output
// pixel. Rejects misrouted, unknown and duplicate packets with a one-cycle
// error pulse and flags when the pixel is complete.
module snn_psum_collector import snn_noc_pkg::*; #(
  parameter logic [3:0]  ADDR         = 4'b0001,
  parameter logic [3:0]  WRAPPER_ADDR = 4'b0100,
  parameter logic [3:0]  PE1_ADDR     = 4'b0010,
  parameter logic [3:0]  PE2_ADDR     = 4'b0110,
  parameter logic [3:0]  PE3_ADDR     = 4'b1010,
  parameter int unsigned PSUM_W       = 12,
  parameter int unsigned POT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  noc_pkt_t          pkt,
  input  logic              first_t,
  input  logic              clear,
  output logic [PSUM_W-1:0] s0,
  output logic [PSUM_W-1:0] s1,
  output logic [PSUM_W-1:0] s2,
  output logic [POT_W-1:0]  pot,
  output logic              complete,
  output logic              err_pkt
);

  logic [PSUM_W-1:0] slot_q [3];
  logic [PSUM_W-1:0] slot_d [3];
  logic [2:0]        slot_valid_q, slot_valid_d;
  logic [POT_W-1:0]  pot_q, pot_d;
  logic              pot_valid_q, pot_valid_d;
  logic              err_q, err_d;
  logic [2:0]        slot_hit;
  logic              is_mem;

  logic unused_payload;
  assign unused_payload = ^pkt.payload[PAYLOAD_W-1:PSUM_W];

  // Decode an accepted packet into a slot/pot write or an error.
  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    pot_d        = pot_q;
    pot_valid_d  = pot_valid_q;
    err_d        = 1'b0;
    slot_hit     = 3'b000;
    is_mem       = (pkt.ptype == TYPE_MEM) && (pkt.src == WRAPPER_ADDR);
    if (pkt.ptype == TYPE_PSUM) begin
      slot_hit = {pkt.src == PE3_ADDR, pkt.src == PE2_ADDR, pkt.src == PE1_ADDR};
    end
    if (clear) begin
      slot_valid_d = 3'b000;
      pot_valid_d  = 1'b0;
    end else if (accept) begin
      if (pkt.dst != ADDR) begin
        err_d = 1'b1;
      end else if (slot_hit != 3'b000) begin
        for (int k = 0; k < 3; k++) begin
          if (slot_hit[k]) begin
            if (slot_valid_q[k]) begin
              // First value wins; the repeat is discarded.
              err_d = 1'b1;
            end else begin
              slot_d[k]       = pkt.payload[PSUM_W-1:0];
              slot_valid_d[k] = 1'b1;
            end
          end
        end
      end else if (is_mem) begin
        // There is no old potential during the first timestep.
        if (first_t || pot_valid_q) begin
          err_d = 1'b1;
        end else begin
          pot_d       = pkt.payload[POT_W-1:0];
          pot_valid_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Slot, potential and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) slot_q[k] <= '0;
      slot_valid_q <= 3'b000;
      pot_q        <= '0;
      pot_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) slot_q[k] <= slot_d[k];
      slot_valid_q <= slot_valid_d;
      pot_q        <= pot_d;
      pot_valid_q  <= pot_valid_d;
      err_q        <= err_d;
    end
  end

  assign s0       = slot_q[0];
  assign s1       = slot_q[1];
  assign s2       = slot_q[2];
  assign pot      = pot_valid_q ? pot_q : '0;
  assign complete = (&slot_valid_q) && (first_t || pot_valid_q);
  assign err_pkt  = err_q;

endmodule

// File: rtl/snn_adder_node.sv
// Membrane-potential accumulator for one output column. Sums three partial
// sums plus the old potential, thresholds the total and returns a spike or an
// updated potential to the memory wrapper, then a DONE after each timestep.
module snn_adder_node import snn_noc_pkg::*; #(
  parameter logic [3:0]  ADDR         = 4'b0001,
  parameter int unsigned COL          = 0,
  parameter logic [3:0]  WRAPPER_ADDR = 4'b0100,
  parameter logic [3:0]  PE1_ADDR     = 4'b0010,
  parameter logic [3:0]  PE2_ADDR     = 4'b0110,
  parameter logic [3:0]  PE3_ADDR     = 4'b1010,
  parameter int unsigned THRESHOLD    = 64,
  parameter int unsigned OFX          = 3,
  parameter int unsigned TIMESTEPS    = 10,
  parameter int unsigned WIDTH_NOC    = 34,
  parameter int unsigned PSUM_W       = 12,
  parameter int unsigned POT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_NOC-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH_NOC-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_pkt,
  output logic [3:0]           cur_t
);

  localparam int unsigned SumW    = 14;
  localparam logic [1:0]  ColBits = 2'(COL);

  typedef enum logic [1:0] {
    StCollect,
    StCompute,
    StSendRes,
    StSendDone
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           row_q, row_d;
  logic [3:0]           cur_t_q, cur_t_d;
  logic [WIDTH_NOC-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  noc_pkt_t          pkt;
  logic              accept;
  logic              clear;
  logic              first_t;
  logic              complete;
  logic [PSUM_W-1:0] s0, s1, s2;
  logic [POT_W-1:0]  pot;
  logic [SumW-1:0]   sum;
  logic [POT_W-1:0]  pot_new;
  noc_pkt_t          result;

  assign pkt      = noc_pkt_t'(in_data);
  assign first_t  = (cur_t_q == 4'd1);
  // Stop accepting once the pixel is complete so nothing lands on a full slot.
  assign in_ready = (state_q == StCollect) && !complete;
  assign accept   = in_valid && in_ready;
  assign clear    = (state_q == StSendRes) && out_ready;

  snn_psum_collector #(
    .ADDR         (ADDR),
    .WRAPPER_ADDR (WRAPPER_ADDR),
    .PE1_ADDR     (PE1_ADDR),
    .PE2_ADDR     (PE2_ADDR),
    .PE3_ADDR     (PE3_ADDR),
    .PSUM_W       (PSUM_W),
    .POT_W        (POT_W)
  ) u_collector (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .pkt      (pkt),
    .first_t  (first_t),
    .clear    (clear),
    .s0       (s0),
    .s1       (s1),
    .s2       (s2),
    .pot      (pot),
    .complete (complete),
    .err_pkt  (err_pkt)
  );

  // Threshold the accumulated potential and format the result packet.
  always_comb begin
    sum     = SumW'(pot) + SumW'(s0) + SumW'(s1) + SumW'(s2);
    pot_new = sum[POT_W-1:0];
    result  = pkt_make(ADDR, WRAPPER_ADDR, TYPE_SPIKE, {20'b0, row_q[1:0], ColBits});
    if (sum < SumW'(THRESHOLD)) begin
      // Keep a potential with low nibble 1111 from being mistaken for DONE.
      if (pot_new[3:0] == DONE_NIBBLE) pot_new = pot_new - 1'b1;
      result = pkt_make(ADDR, WRAPPER_ADDR, TYPE_MEM, 24'(pot_new));
    end
  end

  // Next-state and output register logic.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cur_t_d     = cur_t_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StCollect: begin
        if (complete) state_d = StCompute;
      end
      StCompute: begin
        out_data_d  = result;
        out_valid_d = 1'b1;
        state_d     = StSendRes;
      end
      StSendRes: begin
        if (out_ready) begin
          row_d = row_q + 4'd1;
          if (row_q == 4'(OFX - 1)) begin
            out_data_d  = pkt_make(ADDR, WRAPPER_ADDR, TYPE_SPIKE, DONE_PAYLOAD);
            out_valid_d = 1'b1;
            state_d     = StSendDone;
          end else begin
            out_valid_d = 1'b0;
            state_d     = StCollect;
          end
        end
      end
      StSendDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          row_d       = 4'd0;
          cur_t_d     = (cur_t_q == 4'(TIMESTEPS)) ? 4'd1 : cur_t_q + 4'd1;
          state_d     = StCollect;
        end
      end
    endcase
  end

  // FSM state, counters and output packet registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      row_q       <= 4'd0;
      cur_t_q     <= 4'd1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cur_t_q     <= cur_t_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign cur_t     = cur_t_q;

endmodule

// File: tb/tb_snn_adder_node.sv
// Scoreboard bench for snn_adder_node (ADDR 0101, COL 1, THRESHOLD 64).
module tb_snn_adder_node;

  localparam logic [3:0] A  = 4'b0101;
  localparam logic [3:0] W  = 4'b0100;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0110;
  localparam logic [3:0] P3 = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_pkt;
  logic [3:0]  cur_t;

  always #5 clk = ~clk;

  snn_adder_node #(
    .ADDR      (A),
    .COL       (1),
    .THRESHOLD (64),
    .OFX       (3),
    .TIMESTEPS (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pkt   (err_pkt),
    .cur_t     (cur_t)
  );

  logic [33:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;

  function automatic logic [33:0] psum(input logic [3:0] pe, input logic [11:0] v);
    return {pe, A, 2'b00, 12'b0, v};
  endfunction
  function automatic logic [33:0] mpot(input logic [7:0] v);
    return {W, A, 2'b10, 16'b0, v};
  endfunction
  function automatic logic [33:0] exp_pot(input logic [7:0] v);
    return {A, W, 2'b10, 16'b0, v};
  endfunction
  function automatic logic [33:0] exp_spike(input logic [1:0] row);
    return {A, W, 2'b11, 20'b0, row, 2'b01};
  endfunction
  function automatic logic [33:0] exp_done();
    return {A, W, 2'b11, 24'hFFFFFF};
  endfunction

  // Monitor: a handshake seen at the falling edge completes on the next rise.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL out_unexpected got=%h", out_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("FAIL out_pkt got=%h exp=%h", out_data, e);
        end
      end
    end
    if (err_pkt === 1'b1) err_seen++;
  end

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Offer a packet and return one step after the accepting edge.
  task automatic send(input logic [33:0] p);
    int n = 0;
    in_data  = p;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_bad(input string name, input logic [33:0] p);
    send(p);
    check(name, {33'b0, err_pkt}, 34'd1);
  endtask

  task automatic pixel(input logic [33:0] e, input logic [7:0] pv, input logic [11:0] a,
                       input logic [11:0] b, input logic [11:0] c, input bit with_pot);
    exp_q.push_back(e);
    if (with_pot) send(mpot(pv));
    send(psum(P1, a));
    send(psum(P2, b));
    send(psum(P3, c));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {33'b0, in_ready}, 34'd1);
    check("rst_out_valid", {33'b0, out_valid}, 34'd0);
    check("rst_out_data", out_data, 34'd0);
    check("rst_err", {33'b0, err_pkt}, 34'd0);
    check("rst_cur_t", {30'b0, cur_t}, 34'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // t=1 row 0: 10+20+30 = 60, with latency check.
    exp_q.push_back(exp_pot(8'd60));
    send(psum(P1, 12'd10));
    send(psum(P2, 12'd20));
    send(psum(P3, 12'd30));
    check("lat_in_ready_low", {33'b0, in_ready}, 34'd0);
    check("lat_e0_valid", {33'b0, out_valid}, 34'd0);
    @(posedge clk); #1;
    check("lat_e1_valid", {33'b0, out_valid}, 34'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", {33'b0, out_valid}, 34'd1);

    // t=1 row 1: sum 15 aliases to 14.
    pixel(exp_pot(8'd14), 8'd0, 12'd5, 12'd5, 12'd5, 1'b0);

    // t=1 row 2: dropped packets, then 7+1+1 = 9 under back-pressure.
    send_bad("err_mempot_t1", mpot(8'd3));
    send(psum(P1, 12'd7));
    send_bad("err_dup", psum(P1, 12'd7));
    send_bad("err_dst", {P2, 4'b0001, 2'b00, 24'd1});
    send_bad("err_src", {4'b1111, A, 2'b00, 24'd1});
    exp_q.push_back(exp_pot(8'd9));
    exp_q.push_back(exp_done());
    send(psum(P2, 12'd1));
    out_ready = 1'b0;
    send(psum(P3, 12'd1));
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {33'b0, out_valid}, 34'd1);
      check("stall_data", out_data, exp_pot(8'd9));
      check("stall_in_ready", {33'b0, in_ready}, 34'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_next_cycle", {out_valid, out_data}, {1'b1, exp_done()});
    drain();
    check("cur_t_2", {30'b0, cur_t}, 34'd2);
    check("err_count", 34'(err_seen), 34'd4);

    // t=2: spike at 70, out-of-order arrival, alias at 63.
    pixel(exp_spike(2'd0), 8'd40, 12'd10, 12'd10, 12'd10, 1'b1);
    exp_q.push_back(exp_pot(8'd10));
    send(psum(P3, 12'd3));
    send(psum(P1, 12'd1));
    send(mpot(8'd4));
    send(psum(P2, 12'd2));
    exp_q.push_back(exp_pot(8'd62));
    exp_q.push_back(exp_done());
    send(psum(P2, 12'd0));
    send(mpot(8'd0));
    send(psum(P1, 12'd0));
    send(psum(P3, 12'd63));
    drain();
    check("cur_t_3", {30'b0, cur_t}, 34'd3);

    // t=3: sum exactly at threshold spikes; spike row 2 carries row bits.
    pixel(exp_spike(2'd0), 8'd4, 12'd20, 12'd20, 12'd20, 1'b1);
    pixel(exp_pot(8'd0), 8'd0, 12'd0, 12'd0, 12'd0, 1'b1);
    pixel(exp_spike(2'd2), 8'd255, 12'd0, 12'd0, 12'd0, 1'b1);
    exp_q.push_back(exp_done());
    drain();

    // t=4..10 with zero data, then cur_t wraps to 1.
    for (int t = 4; t <= 10; t++) begin
      for (int r = 0; r < 3; r++) pixel(exp_pot(8'd0), 8'd0, 12'd0, 12'd0, 12'd0, 1'b1);
      exp_q.push_back(exp_done());
      drain();
    end
    check("cur_t_wrap", {30'b0, cur_t}, 34'd1);

    // Reset with a result pending: output is dropped.
    out_ready = 1'b0;
    send(psum(P1, 12'd1));
    send(psum(P2, 12'd2));
    send(psum(P3, 12'd3));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_pending_valid", {33'b0, out_valid}, 34'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset with two slots filled: a fresh pixel sees no stale values.
    send(psum(P1, 12'd50));
    send(psum(P2, 12'd50));
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {33'b0, out_valid}, 34'd0);
    check("rst_mid_cur_t", {30'b0, cur_t}, 34'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pixel(exp_pot(8'd3), 8'd0, 12'd1, 12'd1, 12'd1, 1'b0);
    drain();
    check("err_count_final", 34'(err_seen), 34'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
